// File: rtl/decoder_16_to_4_deinterleaver_if.sv
// Branch-select bus between the deinterleaver commutator and the branch decoder.
interface decoder_16_to_4_deinterleaver_if #(
    parameter int unsigned ERR_CNT_W = 8
);
    logic                 din_valid;
    logic                 din1, din2, din3, din4, din5, din6;
    logic                 din7, din8, din9, din10, din11, din12;
    logic [3:0]           dout;
    logic                 dout_valid;
    logic                 onehot_err;
    logic                 seq_err;
    logic                 locked;
    logic                 frame_done;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output din_valid, din1, din2, din3, din4, din5, din6,
        output din7, din8, din9, din10, din11, din12,
        input  dout, dout_valid, onehot_err, seq_err, locked, frame_done, err_cnt
    );

    modport slave (
        input  din_valid, din1, din2, din3, din4, din5, din6,
        input  din7, din8, din9, din10, din11, din12,
        output dout, dout_valid, onehot_err, seq_err, locked, frame_done, err_cnt
    );
endinterface

// File: rtl/decoder_16_to_4_deinterleaver.sv
// Re-encodes the 12 one-hot commutator selects into a registered branch index and
// tracks commutator sequencing (lock, frame boundary, saturating error count).
module decoder_16_to_4_deinterleaver #(
    parameter int unsigned ERR_CNT_W  = 8,
    parameter int unsigned NUM_BRANCH = 12
) (
    input logic                           clk,
    input logic                           rst_n,
    decoder_16_to_4_deinterleaver_if.slave bus
);

    typedef enum logic [0:0] {StUnlock, StLocked} state_e;

    localparam logic [3:0]           LastBranch = 4'(NUM_BRANCH);
    localparam logic [ERR_CNT_W-1:0] ErrCntMax  = {ERR_CNT_W{1'b1}};

    state_e               state_q, state_d;
    logic [3:0]           exp_q, exp_d;
    logic [3:0]           dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 onehot_err_q, onehot_err_d;
    logic                 seq_err_q, seq_err_d;
    logic                 frame_done_q, frame_done_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [11:0] sel;
    logic        legal;
    logic [3:0]  idx;

    assign sel = {bus.din12, bus.din11, bus.din10, bus.din9, bus.din8, bus.din7,
                  bus.din6, bus.din5, bus.din4, bus.din3, bus.din2, bus.din1};

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign legal = (sel != 12'd0) && ((sel & (sel - 12'd1)) == 12'd0);

    always_comb begin
        idx = 4'd0;
        for (int k = 0; k < 12; k++) begin
            if (sel[k]) idx = 4'(k + 1);
        end
    end

    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        dout_d       = dout_q;
        dout_valid_d = bus.din_valid;
        onehot_err_d = 1'b0;
        seq_err_d    = 1'b0;
        frame_done_d = 1'b0;
        err_cnt_d    = err_cnt_q;

        if (bus.din_valid) begin
            dout_d       = legal ? idx : 4'd0;
            onehot_err_d = ~legal;

            unique case (state_q)
                StUnlock: begin
                    if (legal && idx == 4'd1) begin
                        state_d = StLocked;
                        exp_d   = 4'd2;
                    end
                end
                StLocked: begin
                    if (legal && idx == exp_q) begin
                        exp_d        = (exp_q == LastBranch) ? 4'd1 : exp_q + 4'd1;
                        frame_done_d = (idx == LastBranch);
                    end else begin
                        seq_err_d = 1'b1;
                        // A clean branch 1 is a resync, not a loss of lock.
                        if (legal && idx == 4'd1) begin
                            exp_d = 4'd2;
                        end else begin
                            state_d = StUnlock;
                            exp_d   = 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = StUnlock;
                    exp_d   = 4'd1;
                end
            endcase

            if ((onehot_err_d || seq_err_d) && err_cnt_q != ErrCntMax) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StUnlock;
            exp_q        <= 4'd1;
            dout_q       <= 4'd0;
            dout_valid_q <= 1'b0;
            onehot_err_q <= 1'b0;
            seq_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            onehot_err_q <= onehot_err_d;
            seq_err_q    <= seq_err_d;
            frame_done_q <= frame_done_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.onehot_err = onehot_err_q;
    assign bus.seq_err    = seq_err_q;
    assign bus.locked     = (state_q == StLocked);
    assign bus.frame_done = frame_done_q;
    assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_decoder_16_to_4_deinterleaver.sv
// Directed plus randomized bench for the deinterleaver branch decoder; a second
// instance with a 2-bit error counter shares the stimulus to exercise saturation.
module tb_decoder_16_to_4_deinterleaver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decoder_16_to_4_deinterleaver_if #(.ERR_CNT_W(8)) bus ();
    decoder_16_to_4_deinterleaver_if #(.ERR_CNT_W(2)) sbus ();

    decoder_16_to_4_deinterleaver #(.ERR_CNT_W(8), .NUM_BRANCH(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    decoder_16_to_4_deinterleaver #(.ERR_CNT_W(2), .NUM_BRANCH(12)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state, written directly from the sequencing rules.
    bit m_locked;
    int m_exp, m_cnt, m_dout;
    bit m_dv, m_oh, m_se, m_fd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_exp = 1; m_cnt = 0; m_dout = 0;
        m_dv = 0; m_oh = 0; m_se = 0; m_fd = 0;
    endtask

    task automatic model_step(input bit v, input logic [12:1] s);
        int n, k;
        bit lg;
        m_dv = v; m_oh = 0; m_se = 0; m_fd = 0;
        if (!v) return;
        n = $countones(s);
        k = 0;
        for (int i = 1; i <= 12; i++) if (s[i]) k = i;
        lg = (n == 1);
        m_dout = lg ? k : 0;
        m_oh = !lg;
        if (!m_locked) begin
            if (lg && k == 1) begin m_locked = 1; m_exp = 2; end
        end else if (lg && k == m_exp) begin
            m_fd = (k == 12);
            m_exp = m_exp % 12 + 1;
        end else begin
            m_se = 1;
            if (lg && k == 1) m_exp = 2;
            else begin m_locked = 0; m_exp = 1; end
        end
        if ((m_oh || m_se) && m_cnt < 255) m_cnt++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dout"}, 32'(bus.dout), 32'(m_dout));
        chk({tag, ".dout_valid"}, 32'(bus.dout_valid), 32'(m_dv));
        chk({tag, ".onehot_err"}, 32'(bus.onehot_err), 32'(m_oh));
        chk({tag, ".seq_err"}, 32'(bus.seq_err), 32'(m_se));
        chk({tag, ".locked"}, 32'(bus.locked), 32'(m_locked));
        chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'(m_fd));
        chk({tag, ".err_cnt"}, 32'(bus.err_cnt), 32'(m_cnt));
        chk({tag, ".sat_err_cnt"}, 32'(sbus.err_cnt), 32'((m_cnt > 3) ? 3 : m_cnt));
    endtask

    task automatic apply(input bit v, input logic [12:1] s);
        bus.din_valid = v;  sbus.din_valid = v;
        bus.din1  = s[1];   sbus.din1  = s[1];
        bus.din2  = s[2];   sbus.din2  = s[2];
        bus.din3  = s[3];   sbus.din3  = s[3];
        bus.din4  = s[4];   sbus.din4  = s[4];
        bus.din5  = s[5];   sbus.din5  = s[5];
        bus.din6  = s[6];   sbus.din6  = s[6];
        bus.din7  = s[7];   sbus.din7  = s[7];
        bus.din8  = s[8];   sbus.din8  = s[8];
        bus.din9  = s[9];   sbus.din9  = s[9];
        bus.din10 = s[10];  sbus.din10 = s[10];
        bus.din11 = s[11];  sbus.din11 = s[11];
        bus.din12 = s[12];  sbus.din12 = s[12];
    endtask

    function automatic logic [12:1] oh(input int k);
        logic [12:1] r;
        r = '0;
        if (k >= 1 && k <= 12) r[k] = 1'b1;
        return r;
    endfunction

    task automatic step(input string tag, input bit v, input logic [12:1] s);
        apply(v, s);
        model_step(v, s);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic send(input string tag, input int k);
        step(tag, 1'b1, oh(k));
    endtask

    // Reset is asserted between edges and must clear outputs without a clock.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        apply(1'b1, oh(5));
        @(posedge clk);
        #1;
        check_all({tag, ".hold"});
        rst_n = 1'b1;
    endtask

    initial begin
        logic [12:1] s;
        int r, nxt;
        model_reset();
        apply(1'b0, '0);
        #2;

        do_reset("reset");
        step("first_idle", 1'b0, oh(5));
        for (int k = 1; k <= 12; k++) send("clean", k);
        for (int k = 1; k <= 3; k++) send("clean_wrap", k);

        do_reset("reset_oh");
        send("oh_pre", 1);
        send("oh_pre", 2);
        step("oh_illegal", 1'b1, oh(3) | oh(7));

        do_reset("reset_skip");
        send("skip_pre", 1);
        send("skip_pre", 2);
        send("skip4", 4);
        send("skip5", 5);
        send("relock1", 1);
        for (int k = 2; k <= 6; k++) send("resync_pre", k);
        send("resync1", 1);
        send("resync2", 2);

        do_reset("reset_gap");
        for (int k = 1; k <= 6; k++) send("gap_pre", k);
        for (int i = 0; i < 3; i++) step("gap_idle", 1'b0, 12'($urandom));
        send("gap7", 7);

        do_reset("reset_sat");
        for (int i = 0; i < 5; i++) step("sat_zero", 1'b1, '0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("sat_midreset");
        rst_n = 1'b1;

        do_reset("reset_rand");
        nxt = 1;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            if (r < 2) begin
                step("rand_idle", 1'b0, 12'($urandom));
            end else if (r < 16) begin
                send("rand_seq", nxt);
                nxt = nxt % 12 + 1;
            end else if (r == 16) begin
                send("rand_one", $urandom_range(1, 12));
            end else if (r == 17) begin
                step("rand_zero", 1'b1, '0);
            end else begin
                s = 12'($urandom);
                while ($countones(s) < 2) s = 12'($urandom);
                step("rand_multi", 1'b1, s);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_16_to_4_deinterleaver.md
Name: decoder_16_to_4_deinterleaver

Overview:
Receive-side counterpart of the interleaver's 4-to-12 branch-select decoder. It takes the 12 one-hot branch-select lines driven at the deinterleaver commutator and re-encodes them into a registered 4-bit branch index (1..12). It also checks one-hot legality and commutator sequencing (1,2,...,12,1,...), tracks lock, and counts errors. The result feeds the deinterleaver delay-line address logic and its status registers.

Parameters:
ERR_CNT_W, 8, width of the saturating error counter.
NUM_BRANCH, 12, number of commutator branches; fixed at 12 because the select ports are individual bits.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
din_valid  input  1  din1..din12 carry a branch select this cycle.
din1..din12  input  1 each  one-hot branch-select lines; dinK=1 selects branch K.
dout  output  4  encoded branch index 1..12; 0 means none or illegal.
dout_valid  output  1  dout, onehot_err and seq_err are valid this cycle.
onehot_err  output  1  sample had zero or more than one din line set.
seq_err  output  1  sample index broke the expected commutator sequence.
locked  output  1  sequence tracker is in LOCKED.
frame_done  output  1  one-cycle pulse when branch 12 is accepted in LOCKED.
err_cnt  output  ERR_CNT_W  saturating count of cycles with onehot_err or seq_err.

Behaviour:
- Reset (rst_n=0, asynchronous): dout=0, dout_valid=0, onehot_err=0, seq_err=0, locked=0, frame_done=0, err_cnt=0, state=UNLOCK, expected=1. Reset takes effect immediately mid-operation, and the pipeline sample is discarded.
- Latency: a sample on cycle N with din_valid=1 produces its outputs on cycle N+1. dout_valid is the registered copy of din_valid. All outputs are registered.
- When din_valid=0: dout_valid=0, onehot_err=0, seq_err=0 and frame_done=0 on the next cycle. dout holds its last value. State, expected and err_cnt are unchanged.
- Encoding: if exactly one dinK=1, then dout=K and onehot_err=0. If zero lines or two or more lines are set, then dout=0 and onehot_err=1.
- Sequence FSM, with states UNLOCK and LOCKED. A transition happens only on a valid sample.
  - UNLOCK, legal index 1: go to LOCKED, expected=2, seq_err=0.
  - UNLOCK, any other index or illegal sample: stay in UNLOCK, seq_err=0. Unlocked samples are not sequence errors; onehot_err is still reported.
  - LOCKED, legal index equal to expected: stay in LOCKED. expected advances by 1, wrapping 12 to 1. frame_done=1 when the index is 12.
  - LOCKED, mismatch or onehot_err: seq_err=1. If the sample is legal index 1, resync: stay in LOCKED with expected=2. Otherwise go to UNLOCK with expected=1.
- locked=1 exactly when the state is LOCKED. It updates in the same cycle as dout_valid for the causing sample.
- err_cnt increments by 1 on any output cycle where onehot_err=1 or seq_err=1 (once per sample even if both are set). It saturates at 2^ERR_CNT_W-1 and never wraps.
- frame_done is never asserted together with seq_err.

Test Plan:
- Reset: hold rst_n=0, drive din5=1 with din_valid=1 -> all outputs 0 and locked=0. Release rst_n -> first output appears one cycle after the first valid sample.
- Clean sequence: valid samples for branches 1..12 then 1..3 -> dout=1..12,1..3 at latency 1. locked=1 from the first output. frame_done pulses only on the cycle dout=12. seq_err=0 and err_cnt=0 throughout.
- Illegal one-hot while LOCKED: din3 and din7 both set when expected=3 -> dout=0, onehot_err=1, seq_err=1, locked=0, err_cnt=1.
- Skip and resync: in LOCKED after 1,2, send 4 -> seq_err=1 and locked=0. Then send 5 -> seq_err=0 and stays unlocked. Then send 1 -> locked=1. Also, in LOCKED after 1..6, send 1 -> seq_err=1, locked stays 1, and expected becomes 2.
- Gapped valid: in LOCKED, insert 3 idle cycles (din_valid=0) between 6 and 7 -> dout_valid=0 in the gap, dout holds 6, no errors, lock retained.
- Saturation with ERR_CNT_W=2: send 5 all-zero valid samples -> err_cnt reads 1,2,3,3,3. Assert rst_n=0 mid-stream -> err_cnt=0 immediately.
